// File: rtl/ysyx_mem_arbiter.sv
// Two-requester memory arbiter: IFU reads and LSU loads/stores share one bus port.
// A single latched transaction is in flight at a time; it has a timeout and an IFU anti-starvation limit.
module ysyx_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    output logic              ifu_err,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic              lsu_err,

    output logic [ADDR_W-1:0] bus_araddr,
    output logic              bus_arvalid,
    input  logic              bus_arready,
    output logic [7:0]        bus_rstrb,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [ADDR_W-1:0] bus_awaddr,
    output logic              bus_awvalid,
    input  logic              bus_awready,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [7:0]        bus_wstrb,
    output logic              bus_wvalid,
    input  logic              bus_wready,
    input  logic              bus_bvalid
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] S_ONE  = SW'(1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_IFU, G_LSU_RD, G_LSU_WR} grant_t;

    typedef struct packed {
        logic              owner_ifu;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        rstrb;
        logic [DATA_W-1:0] wdata;
        logic [7:0]        wstrb;
    } txn_t;

    state_t        state, state_nxt;
    grant_t        grant;
    txn_t          txn, txn_nxt;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] starve;
    logic          ar_done, aw_done, w_done;

    logic          wr_req;
    logic          rd_fire, wr_fire, tmo, tcnt_last;

    // Store address and data valids are identical by contract; either one requests a store.
    assign wr_req = lsu_awvalid | lsu_wvalid;

    always_comb begin
        grant = G_NONE;
        if (wr_req)
            grant = G_LSU_WR;
        else if (lsu_arvalid && ifu_arvalid)
            grant = (starve == S_MAX) ? G_IFU : G_LSU_RD;
        else if (lsu_arvalid)
            grant = G_LSU_RD;
        else if (ifu_arvalid)
            grant = G_IFU;
    end

    always_comb begin
        txn_nxt = '0;
        case (grant)
            G_IFU: begin
                txn_nxt.owner_ifu = 1'b1;
                txn_nxt.addr      = ifu_araddr;
                txn_nxt.rstrb     = 8'h0f;
            end
            G_LSU_RD: begin
                txn_nxt.addr  = lsu_araddr;
                txn_nxt.rstrb = lsu_rstrb;
            end
            G_LSU_WR: begin
                txn_nxt.addr  = lsu_awaddr;
                txn_nxt.wdata = lsu_wdata;
                txn_nxt.wstrb = lsu_wstrb;
            end
            default: txn_nxt = '0;
        endcase
    end

    // A response arriving with the last address/data handshake counts; a real completion
    // in the final counted cycle wins over the timeout.
    assign tcnt_last = (tcnt == T_LAST);
    assign rd_fire   = (state == RD) && (ar_done || bus_arready) && bus_rvalid;
    assign wr_fire   = (state == WR) && (aw_done || bus_awready)
                                     && (w_done  || bus_wready) && bus_bvalid;
    assign tmo       = tcnt_last && (((state == RD) && !rd_fire) ||
                                     ((state == WR) && !wr_fire));

    always_comb begin
        state_nxt   = state;
        bus_arvalid = 1'b0;
        bus_awvalid = 1'b0;
        bus_wvalid  = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_err     = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_wready  = 1'b0;
        lsu_err     = 1'b0;
        case (state)
            IDLE: begin
                case (grant)
                    G_IFU, G_LSU_RD: state_nxt = RD;
                    G_LSU_WR:        state_nxt = WR;
                    default:         state_nxt = IDLE;
                endcase
            end
            RD: begin
                bus_arvalid = !ar_done && !tmo;
                if (rd_fire || tmo) begin
                    state_nxt = DONE;
                    if (txn.owner_ifu) begin
                        ifu_rvalid = 1'b1;
                        ifu_err    = tmo;
                        ifu_rdata  = rd_fire ? bus_rdata : '0;
                    end else begin
                        lsu_rvalid = 1'b1;
                        lsu_err    = tmo;
                        lsu_rdata  = rd_fire ? bus_rdata : '0;
                    end
                end
            end
            WR: begin
                bus_awvalid = !aw_done && !tmo;
                bus_wvalid  = !w_done && !tmo;
                if (wr_fire || tmo) begin
                    state_nxt  = DONE;
                    lsu_wready = 1'b1;
                    lsu_err    = tmo;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_araddr = txn.addr;
    assign bus_awaddr = txn.addr;
    assign bus_rstrb  = txn.rstrb;
    assign bus_wdata  = txn.wdata;
    assign bus_wstrb  = txn.wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txn     <= '0;
            tcnt    <= '0;
            starve  <= '0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant != G_NONE) begin
                        txn     <= txn_nxt;
                        tcnt    <= '0;
                        ar_done <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                    if (grant == G_IFU)
                        starve <= '0;
                    else if (grant != G_NONE && ifu_arvalid && starve != S_MAX)
                        starve <= starve + S_ONE;
                end
                RD: begin
                    tcnt <= tcnt + T_ONE;
                    if (bus_arvalid && bus_arready)
                        ar_done <= 1'b1;
                end
                WR: begin
                    tcnt <= tcnt + T_ONE;
                    if (bus_awvalid && bus_awready)
                        aw_done <= 1'b1;
                    if (bus_wvalid && bus_wready)
                        w_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: inputs change 1 ns after the rising edge,
// outputs are sampled 3 ns after it.
module tb_ysyx_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ifu_araddr;
    logic          ifu_arvalid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_rvalid, ifu_err;
    logic [AW-1:0] lsu_araddr;
    logic          lsu_arvalid;
    logic [7:0]    lsu_rstrb;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_rvalid;
    logic [AW-1:0] lsu_awaddr;
    logic          lsu_awvalid;
    logic [DW-1:0] lsu_wdata;
    logic [7:0]    lsu_wstrb;
    logic          lsu_wvalid, lsu_wready, lsu_err;
    logic [AW-1:0] bus_araddr;
    logic          bus_arvalid, bus_arready;
    logic [7:0]    bus_rstrb;
    logic [DW-1:0] bus_rdata;
    logic          bus_rvalid;
    logic [AW-1:0] bus_awaddr;
    logic          bus_awvalid, bus_awready;
    logic [DW-1:0] bus_wdata;
    logic [7:0]    bus_wstrb;
    logic          bus_wvalid, bus_wready, bus_bvalid;

    int pass_cnt = 0;
    int total    = 0;

    ysyx_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata),
        .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_err(lsu_err),
        .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_rstrb(bus_rstrb), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid),
        .bus_wready(bus_wready), .bus_bvalid(bus_bvalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ifu_araddr = '0; ifu_arvalid = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = '0;
        lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
        bus_arready = 1'b0; bus_rdata = '0; bus_rvalid = 1'b0;
        bus_awready = 1'b0; bus_wready = 1'b0; bus_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst = 1'b1;
        clear_in();
        tick(); tick();
        rst = 1'b0;
        #2;
        flags = {ifu_rvalid, ifu_err, lsu_rvalid, lsu_wready, lsu_err, bus_arvalid, bus_awvalid, bus_wvalid};
        total++; if (flags !== 8'h00) $display("FAIL reset_flags got %h exp 00", flags); else pass_cnt++;
        total++; if (bus_araddr !== 32'h0) $display("FAIL reset_araddr got %h exp 0", bus_araddr); else pass_cnt++;
        total++; if ({bus_rstrb, bus_wstrb} !== 16'h0) $display("FAIL reset_strb got %h exp 0", {bus_rstrb, bus_wstrb}); else pass_cnt++;
        total++; if (bus_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", bus_wdata); else pass_cnt++;
    endtask

    task automatic test_ifu_read();
        logic lsu_seen = 1'b0;
        tick(); ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; #2;          // c0
        lsu_seen |= lsu_rvalid;
        total++; if (bus_arvalid !== 1'b0) $display("FAIL ifu_c0_arvalid got %b exp 0", bus_arvalid); else pass_cnt++;
        tick(); bus_arready = 1'b1; #2;                                        // c1
        lsu_seen |= lsu_rvalid;
        total++; if (bus_arvalid !== 1'b1) $display("FAIL ifu_c1_arvalid got %b exp 1", bus_arvalid); else pass_cnt++;
        total++; if (bus_araddr !== 32'h8000_0000) $display("FAIL ifu_c1_araddr got %h exp 80000000", bus_araddr); else pass_cnt++;
        total++; if (bus_rstrb !== 8'h0f) $display("FAIL ifu_rstrb got %h exp 0f", bus_rstrb); else pass_cnt++;
        total++; if (ifu_rvalid !== 1'b0) $display("FAIL ifu_c1_rvalid got %b exp 0", ifu_rvalid); else pass_cnt++;
        tick(); bus_arready = 1'b0; #2;                                        // c2
        lsu_seen |= lsu_rvalid;
        total++; if ({bus_arvalid, ifu_rvalid} !== 2'b00) $display("FAIL ifu_c2_arvalid_rvalid got %b exp 00", {bus_arvalid, ifu_rvalid}); else pass_cnt++;
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'hdead_beef; #2;              // c3
        lsu_seen |= lsu_rvalid;
        total++; if ({ifu_rvalid, ifu_err} !== 2'b10) $display("FAIL ifu_c3_rvalid_err got %b exp 10", {ifu_rvalid, ifu_err}); else pass_cnt++;
        total++; if (ifu_rdata !== 32'hdead_beef) $display("FAIL ifu_c3_rdata got %h exp deadbeef", ifu_rdata); else pass_cnt++;
        tick(); bus_rvalid = 1'b0; bus_rdata = '0; ifu_arvalid = 1'b0; #2;    // c4 DONE
        lsu_seen |= lsu_rvalid;
        total++; if ({ifu_rvalid, bus_arvalid} !== 2'b00) $display("FAIL ifu_c4_done got %b exp 00", {ifu_rvalid, bus_arvalid}); else pass_cnt++;
        tick(); #2;                                                            // c5 IDLE
        lsu_seen |= lsu_rvalid;
        total++; if (lsu_seen !== 1'b0) $display("FAIL ifu_lsu_rvalid_leak got %b exp 0", lsu_seen); else pass_cnt++;
        clear_in();
    endtask

    task automatic test_starve();
        logic order [10];
        int   n = 0;
        tick();
        ifu_araddr = 32'h100; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h200; lsu_arvalid = 1'b1; lsu_rstrb = 8'h0f;
        bus_arready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5a5a_0000;
        for (int c = 0; c < 40 && n < 10; c++) begin
            tick(); #2;
            if (ifu_rvalid || lsu_rvalid) begin
                order[n] = ifu_rvalid;
                n++;
            end
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        total++; if (n !== 10) $display("FAIL starve_resp_count got %0d exp 10", n); else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            total++;
            if (order[i] !== ((i == 4) || (i == 9)))
                $display("FAIL starve_grant_%0d got ifu=%b exp ifu=%b", i, order[i], (i == 4) || (i == 9));
            else pass_cnt++;
        end
        tick(); tick();
        clear_in();
    endtask

    task automatic test_store();
        logic ar_seen = 1'b0;
        tick();                                                                // c0
        lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'h1234; lsu_wstrb = 8'h03;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; #2;
        total++; if ({bus_awvalid, bus_wvalid} !== 2'b00) $display("FAIL st_c0_valids got %b exp 00", {bus_awvalid, bus_wvalid}); else pass_cnt++;
        tick(); bus_awready = 1'b1; #2;                                        // c1
        ar_seen |= bus_arvalid;
        total++; if ({bus_awvalid, bus_wvalid, lsu_wready} !== 3'b110) $display("FAIL st_c1_valids got %b exp 110", {bus_awvalid, bus_wvalid, lsu_wready}); else pass_cnt++;
        total++; if (bus_awaddr !== 32'h8000_0010) $display("FAIL st_awaddr got %h exp 80000010", bus_awaddr); else pass_cnt++;
        total++; if ({bus_wdata, bus_wstrb} !== {32'h1234, 8'h03}) $display("FAIL st_wdata_wstrb got %h exp 0000123403", {bus_wdata, bus_wstrb}); else pass_cnt++;
        tick(); bus_awready = 1'b0; bus_wready = 1'b1; #2;                      // c2
        ar_seen |= bus_arvalid;
        total++; if ({bus_awvalid, bus_wvalid} !== 2'b01) $display("FAIL st_c2_valids got %b exp 01", {bus_awvalid, bus_wvalid}); else pass_cnt++;
        tick(); bus_wready = 1'b0; #2;                                         // c3
        ar_seen |= bus_arvalid;
        total++; if ({bus_awvalid, bus_wvalid, lsu_wready} !== 3'b000) $display("FAIL st_c3_valids got %b exp 000", {bus_awvalid, bus_wvalid, lsu_wready}); else pass_cnt++;
        tick(); bus_bvalid = 1'b1; #2;                                         // c4
        ar_seen |= bus_arvalid;
        total++; if ({lsu_wready, lsu_err} !== 2'b10) $display("FAIL st_c4_wready_err got %b exp 10", {lsu_wready, lsu_err}); else pass_cnt++;
        tick(); bus_bvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; #2;   // c5 DONE
        ar_seen |= bus_arvalid;
        total++; if (lsu_wready !== 1'b0) $display("FAIL st_c5_wready got %b exp 0", lsu_wready); else pass_cnt++;
        total++; if (ar_seen !== 1'b0) $display("FAIL st_arvalid_leak got %b exp 0", ar_seen); else pass_cnt++;
        tick();
        clear_in();
    endtask

    task automatic test_timeout();
        int ar_hi = 0;
        logic early = 1'b0;
        tick(); lsu_araddr = 32'h300; lsu_arvalid = 1'b1; lsu_rstrb = 8'hff;
        bus_rdata = 32'hffff_ffff; #2;
        for (int k = 1; k <= 7; k++) begin
            tick(); #2;
            if (bus_arvalid) ar_hi++;
            early |= lsu_rvalid;
        end
        total++; if (ar_hi !== 7) $display("FAIL to_arvalid_cycles got %0d exp 7", ar_hi); else pass_cnt++;
        total++; if (early !== 1'b0) $display("FAIL to_early_rvalid got %b exp 0", early); else pass_cnt++;
        total++; if (bus_rstrb !== 8'hff) $display("FAIL to_rstrb got %h exp ff", bus_rstrb); else pass_cnt++;
        tick(); #2;                                                            // 8th RD cycle
        total++; if ({bus_arvalid, lsu_rvalid, lsu_err, ifu_rvalid} !== 4'b0110) $display("FAIL to_err_pulse got %b exp 0110", {bus_arvalid, lsu_rvalid, lsu_err, ifu_rvalid}); else pass_cnt++;
        total++; if (lsu_rdata !== 32'h0) $display("FAIL to_rdata got %h exp 0", lsu_rdata); else pass_cnt++;
        tick(); lsu_arvalid = 1'b0; bus_arready = 1'b1; bus_rvalid = 1'b1; #2;  // DONE, late response
        total++; if ({lsu_rvalid, lsu_err} !== 2'b00) $display("FAIL to_late_done got %b exp 00", {lsu_rvalid, lsu_err}); else pass_cnt++;
        tick(); #2;                                                            // IDLE, late response
        total++; if ({lsu_rvalid, ifu_rvalid, bus_arvalid} !== 3'b000) $display("FAIL to_late_idle got %b exp 000", {lsu_rvalid, ifu_rvalid, bus_arvalid}); else pass_cnt++;
        clear_in();
    endtask

    task automatic test_store_before_load();
        tick();                                                                // c0
        lsu_awaddr = 32'h400; lsu_wdata = 32'h77; lsu_wstrb = 8'h0f; lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        lsu_araddr = 32'h500; lsu_arvalid = 1'b1; lsu_rstrb = 8'h01;
        bus_awready = 1'b1; bus_wready = 1'b1; bus_bvalid = 1'b1;
        bus_arready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hcafe_0001; #2;
        tick(); #2;                                                            // c1 WR
        total++; if ({bus_awvalid, bus_arvalid, lsu_wready, lsu_rvalid} !== 4'b1010) $display("FAIL sl_c1_wr got %b exp 1010", {bus_awvalid, bus_arvalid, lsu_wready, lsu_rvalid}); else pass_cnt++;
        tick(); lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; #2;                      // c2 DONE
        total++; if ({bus_arvalid, lsu_rvalid, lsu_wready} !== 3'b000) $display("FAIL sl_c2_done got %b exp 000", {bus_arvalid, lsu_rvalid, lsu_wready}); else pass_cnt++;
        tick(); #2;                                                            // c3 IDLE
        total++; if (bus_arvalid !== 1'b0) $display("FAIL sl_c3_idle got %b exp 0", bus_arvalid); else pass_cnt++;
        tick(); #2;                                                            // c4 RD
        total++; if ({bus_arvalid, lsu_rvalid} !== 2'b11) $display("FAIL sl_c4_rd got %b exp 11", {bus_arvalid, lsu_rvalid}); else pass_cnt++;
        total++; if (bus_araddr !== 32'h500) $display("FAIL sl_c4_araddr got %h exp 500", bus_araddr); else pass_cnt++;
        total++; if (lsu_rdata !== 32'hcafe_0001) $display("FAIL sl_c4_rdata got %h exp cafe0001", lsu_rdata); else pass_cnt++;
        tick(); lsu_arvalid = 1'b0; #2;
        tick();
        clear_in();
    endtask

    task automatic test_reset_mid();
        logic [7:0] flags;
        tick(); ifu_araddr = 32'h600; ifu_arvalid = 1'b1; #2;                  // c0
        tick(); bus_arready = 1'b1; #2;                                        // c1
        total++; if (bus_arvalid !== 1'b1) $display("FAIL rm_c1_arvalid got %b exp 1", bus_arvalid); else pass_cnt++;
        tick(); bus_arready = 1'b0; rst = 1'b1; #2;                            // c2 reset asserted
        tick(); rst = 1'b0; ifu_arvalid = 1'b0; #2;                            // c3
        flags = {ifu_rvalid, ifu_err, lsu_rvalid, lsu_wready, lsu_err, bus_arvalid, bus_awvalid, bus_wvalid};
        total++; if (flags !== 8'h00) $display("FAIL rm_c3_flags got %h exp 00", flags); else pass_cnt++;
        total++; if (bus_araddr !== 32'h0) $display("FAIL rm_c3_araddr got %h exp 0", bus_araddr); else pass_cnt++;
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222; #2;              // c4 stale response
        total++; if ({ifu_rvalid, lsu_rvalid, bus_arvalid} !== 3'b000) $display("FAIL rm_c4_stale got %b exp 000", {ifu_rvalid, lsu_rvalid, bus_arvalid}); else pass_cnt++;
        tick();
        clear_in();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_reset();
        test_starve();
        test_store();
        test_timeout();
        test_store_before_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
